vend_ctrl_multi: RTL
====================

# vend_ctrl_multi

Parametrised vending-machine controller and the next-generation successor to the fixed four-item vending block. It supports NUM_ITEMS items with per-item prices, and accumulates credit from nickel, dime and quarter pulses. It dispenses a selected item when credit covers its price and returns change or refunds as a train of nickel pulses. It also tracks per-item stock and sits between the coin-acceptor/keypad front end and the dispense/change actuators.

## Interface
- NUM_ITEMS, 4, number of selectable items (2..16)
- CREDIT_W, 5, width of credit and price values, in nickel units
- PRICES, {5'd6,5'd5,5'd4,5'd3}, packed NUM_ITEMS×CREDIT_W per-item prices in nickels, item 0 in the LSBs; each value is 1..MAX_CREDIT
- MAX_CREDIT, 20, credit ceiling in nickels; must be < 2^CREDIT_W
- STOCK_W, 4, width of each per-item stock counter
- STOCK_MAX, 10, stock value loaded at reset and on restock; must be ≥1
- clock  in  1  single system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears the block immediately
- nickel_in / dime_in / quarter_in  in  1 each  single-cycle coin pulses worth 1, 2 and 5 nickels
- select  in  NUM_ITEMS  one-hot item request, sampled each cycle
- cancel  in  1  refund request
- restock  in  1  reload every stock counter to STOCK_MAX
- dispense  out  1  high for exactly one cycle per vend
- item_out  out  $clog2(NUM_ITEMS)  index of the vended item; valid while dispense=1, otherwise 0
- nickel_out  out  1  one nickel ejected per high cycle
- coin_reject  out  1  one-cycle pulse, registered one cycle after a rejected coin
- credit  out  CREDIT_W  current credit register
- busy  out  1  high in VEND and CHANGE
- sold_out  out  NUM_ITEMS  bit i is high when stock[i]==0

## Operation
- All outputs are registered.
- Reset values: state IDLE, credit=0, dispense=0, item_out=0, nickel_out=0, coin_reject=0, busy=0, every stock counter=STOCK_MAX, sold_out=0.
- The FSM has three states: IDLE, VEND and CHANGE.
- IDLE priority, highest first, one action per cycle:
  - (1) Exactly one coin input high: the coin is accepted if credit+value ≤ MAX_CREDIT and credit increases by value. Otherwise credit is unchanged and coin_reject pulses.
  - (2) Two or more coin inputs high in the same cycle: all are rejected, coin_reject pulses and credit is unchanged.
  - (3) cancel with credit>0: go to CHANGE. cancel with credit=0 is ignored.
  - (4) select one-hot on item i, stock[i]>0 and credit≥PRICES[i]: credit decreases by the price, stock[i] decrements, item_out=i, go to VEND.
- A select that is not one-hot, is for a sold-out item, or lacks sufficient credit is ignored. Credit is retained.
- When a coin arrives in the same cycle as cancel or select, the coin is handled and cancel/select are dropped. The requester must reassert.
- VEND lasts one cycle with dispense=1. The next state is CHANGE if credit>0, otherwise IDLE.
- In CHANGE, nickel_out=1 every cycle and credit decrements by 1 each cycle. The FSM leaves for IDLE on the edge where credit goes 1→0, so a change of k nickels gives exactly k consecutive nickel_out cycles.
- In VEND and CHANGE, every coin is rejected with a coin_reject pulse. select and cancel are ignored.
- restock is honoured in any state. If it coincides with a vend decrement, restock wins and the counter becomes STOCK_MAX.
- Credit arithmetic never wraps, because MAX_CREDIT < 2^CREDIT_W.

## Timing
- A coin pulse at edge t is reflected in credit after t. coin_reject is high in cycle t+1.
- A valid select sampled at edge t gives dispense high in cycle t+1, with credit already reduced by the price. The first nickel_out, if any, is in cycle t+2.
- A cancel sampled at edge t gives nickel_out in cycles t+1 .. t+credit.
- busy is high in exactly the cycles when dispense or nickel_out are high.
- Reset asserted mid-VEND or mid-CHANGE forces every output to its reset value asynchronously. Any remaining change is discarded.

## Test plan
- Reset, then dime followed by nickel (credit 3), then select=0001 → one-cycle dispense with item_out=0, credit 0, no nickel_out, busy for 1 cycle.
- Quarter (credit 5), then select=0010 (price 4) → dispense with item_out=1, then 1 nickel_out cycle; credit ends at 0.
- Dime (credit 2), then select=0100 (price 5) → no dispense and credit stays 2. Then cancel → 2 consecutive nickel_out cycles and credit 0.
- Four quarters (credit 20), then a nickel → coin_reject, credit stays 20. Then nickel_in and dime_in in the same cycle → coin_reject, credit stays 20. A quarter during CHANGE → coin_reject.
- With STOCK_MAX=2, two vends of item 3 → sold_out[3]=1 and a third select=1000 with credit 6 is ignored. Then restock → sold_out=0 and the vend succeeds.
- Credit 5 and select item 0 → assert reset during CHANGE, and all outputs are 0 immediately with credit 0. After release, the FSM is IDLE and accepts coins.

Source files
------------

// File: rtl/vend_ctrl_multi.sv
// Vending controller for NUM_ITEMS priced items: accumulates coin credit, vends on a
// valid select, pays change or refunds as a nickel train, and tracks per-item stock.
module vend_ctrl_multi #(
  parameter int NUM_ITEMS  = 4,
  parameter int CREDIT_W   = 5,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {5'd6, 5'd5, 5'd4, 5'd3},
  parameter int MAX_CREDIT = 20,
  parameter int STOCK_W    = 4,
  parameter int STOCK_MAX  = 10,
  localparam int ITEM_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  nickel_in,
  input  logic                  dime_in,
  input  logic                  quarter_in,
  input  logic [NUM_ITEMS-1:0]  select,
  input  logic                  cancel,
  input  logic                  restock,
  output logic                  dispense,
  output logic [ITEM_W-1:0]     item_out,
  output logic                  nickel_out,
  output logic                  coin_reject,
  output logic [CREDIT_W-1:0]   credit,
  output logic                  busy,
  output logic [NUM_ITEMS-1:0]  sold_out
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t                              state;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0]   stock;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0]   stock_next;
  logic [NUM_ITEMS-1:0]                sold_out_next;

  logic [1:0]            coin_cnt;
  logic                  any_coin;
  logic [CREDIT_W-1:0]   coin_val;
  logic [CREDIT_W:0]     coin_sum;
  logic                  coin_fits;
  logic [ITEM_W-1:0]     sel_idx;
  logic [CREDIT_W-1:0]   sel_price;
  logic                  sel_ok;
  logic                  refund_req;
  logic                  do_vend;

  always_comb begin
    coin_cnt  = {1'b0, nickel_in} + {1'b0, dime_in} + {1'b0, quarter_in};
    any_coin  = nickel_in | dime_in | quarter_in;
    coin_val  = '0;
    if (nickel_in)  coin_val = CREDIT_W'(1);
    if (dime_in)    coin_val = CREDIT_W'(2);
    if (quarter_in) coin_val = CREDIT_W'(5);
    coin_sum  = {1'b0, credit} + {1'b0, coin_val};
    coin_fits = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

    sel_idx   = '0;
    sel_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (select[i]) begin
        sel_idx   = ITEM_W'(i);
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
    sel_ok = $onehot(select) && (stock[sel_idx] != '0) && (credit >= sel_price);

    // Coins outrank cancel, and an effective cancel outranks select.
    refund_req = cancel && (credit != '0);
    do_vend    = (state == IDLE) && !any_coin && !refund_req && sel_ok;

    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_next[i] = stock[i];
      if (restock)
        stock_next[i] = STOCK_W'(STOCK_MAX);
      else if (do_vend && (sel_idx == ITEM_W'(i)))
        stock_next[i] = stock[i] - STOCK_W'(1);
      sold_out_next[i] = (stock_next[i] == '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      dispense    <= 1'b0;
      item_out    <= '0;
      nickel_out  <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
      sold_out    <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_MAX);
    end else begin
      stock       <= stock_next;
      sold_out    <= sold_out_next;
      dispense    <= 1'b0;
      item_out    <= '0;
      nickel_out  <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;

      case (state)
        IDLE: begin
          if (any_coin) begin
            if ((coin_cnt == 2'd1) && coin_fits)
              credit <= coin_sum[CREDIT_W-1:0];
            else
              coin_reject <= 1'b1;
          end else if (refund_req) begin
            state      <= CHANGE;
            nickel_out <= 1'b1;
            busy       <= 1'b1;
          end else if (do_vend) begin
            state    <= VEND;
            credit   <= credit - sel_price;
            dispense <= 1'b1;
            item_out <= sel_idx;
            busy     <= 1'b1;
          end
        end

        VEND: begin
          coin_reject <= any_coin;
          if (credit != '0) begin
            state      <= CHANGE;
            nickel_out <= 1'b1;
            busy       <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        CHANGE: begin
          coin_reject <= any_coin;
          credit      <= credit - CREDIT_W'(1);
          if (credit == CREDIT_W'(1)) begin
            state <= IDLE;
          end else begin
            nickel_out <= 1'b1;
            busy       <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
